// File: rtl/seq_divider_pkg.sv
// seq_divider_pkg: shared definitions for the multicycle signed divider.
// Holds the default datapath width, the FSM state encoding and the
// divide operation code used by the execute-stage decode.
package seq_divider_pkg;

    localparam int WIDTH_DEF = 32;

    // FSM state encoding; the decode/debug logic relies on these values.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } div_state_t;

    // ALU operation code selecting this unit in the execute stage.
    localparam logic [4:0] ALU_OP_DIV = 5'b00111;

endpackage

// File: rtl/seq_divider_div_step.sv
// div_step: one combinational restoring-division step.
// Shifts {rem, quot} left by one, trial-subtracts the divisor from the
// partial remainder and keeps the result only if it did not go negative.
// Ports:
//   rem       - current partial remainder (WIDTH+1 bits, top bit always 0)
//   quot      - current quotient / remaining dividend bits
//   divisor   - divisor magnitude
//   next_rem  - partial remainder after this step
//   next_quot - quotient after this step (new bit shifted into bit 0)
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0]   rem,
    input  logic [WIDTH-1:0] quot,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH:0]   next_rem,
    output logic [WIDTH-1:0] next_quot
);

    logic [WIDTH:0] sh_rem;
    logic [WIDTH:0] trial;
    logic           rem_top_unused;

    // Remainder is always below the divisor, so its top bit is zero on
    // entry; the shift pushes it out without loss.
    assign rem_top_unused = rem[WIDTH];

    assign sh_rem = {rem[WIDTH-1:0], quot[WIDTH-1]};
    // Subtract as add of the one's complement plus one.
    assign trial  = sh_rem + ~{1'b0, divisor} + (WIDTH+1)'(1);

    assign next_rem  = trial[WIDTH] ? sh_rem : trial;
    assign next_quot = {quot[WIDTH-2:0], ~trial[WIDTH]};

endmodule

// File: rtl/seq_divider.sv
// seq_divider: multicycle signed integer divider (restoring, 1 bit/clock).
// A ctrl_DIV pulse captures the operands; WIDTH steps later the
// quotient (truncated toward zero) and remainder (sign of dividend) are
// registered and data_resultRDY pulses for one cycle. Divide by zero
// completes after one cycle with data_exception set.
// Ports:
//   clock, reset          - rising-edge clock, async active-high reset
//   ctrl_DIV              - start pulse (also aborts a running operation)
//   data_operandA/B       - dividend / divisor, two's complement
//   data_result           - quotient
//   data_remainder        - remainder
//   data_exception        - divide-by-zero flag, held until next completion
//   data_resultRDY        - one-cycle completion strobe
//   busy                  - high while iterating or sign-correcting
module seq_divider
    import seq_divider_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNT_W = 5
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ctrl_DIV,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    output logic [WIDTH-1:0] data_result,
    output logic [WIDTH-1:0] data_remainder,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             busy
);

    div_state_t       state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH:0]   rem;
    logic [WIDTH-1:0] quot;
    logic [WIDTH-1:0] divisor;
    logic             sign_q;
    logic             sign_r;
    logic             div0;

    logic [WIDTH:0]   next_rem;
    logic [WIDTH-1:0] next_quot;
    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;

    // Magnitudes; -2^(W-1) maps to itself and is read as unsigned.
    assign mag_a = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
    assign mag_b = data_operandB[WIDTH-1] ? -data_operandB : data_operandB;

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem       (rem),
        .quot      (quot),
        .divisor   (divisor),
        .next_rem  (next_rem),
        .next_quot (next_quot)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            cnt            <= '0;
            rem            <= '0;
            quot           <= '0;
            divisor        <= '0;
            sign_q         <= 1'b0;
            sign_r         <= 1'b0;
            div0           <= 1'b0;
            data_result    <= '0;
            data_remainder <= '0;
            data_exception <= 1'b0;
            data_resultRDY <= 1'b0;
            busy           <= 1'b0;
        end else begin
            data_resultRDY <= 1'b0;
            case (state)
                RUN: begin
                    rem  <= next_rem;
                    quot <= next_quot;
                    if (cnt == CNT_W'(WIDTH-1)) state <= FIX;
                    else                        cnt   <= cnt + CNT_W'(1);
                end
                FIX: begin
                    data_result    <= sign_q ? -quot : quot;
                    data_remainder <= sign_r ? -rem[WIDTH-1:0] : rem[WIDTH-1:0];
                    data_exception <= 1'b0;
                    busy           <= 1'b0;
                    state          <= DONE;
                end
                DONE: begin
                    // Results are already final here, so a start on this
                    // edge is a back-to-back issue, not an abort.
                    data_resultRDY <= 1'b1;
                    if (div0) begin
                        // quot still holds |A|; re-apply the dividend sign.
                        data_result    <= '0;
                        data_remainder <= sign_r ? -quot : quot;
                        data_exception <= 1'b1;
                    end
                    state <= IDLE;
                end
                default: ;
            endcase

            if (ctrl_DIV) begin
                rem     <= '0;
                quot    <= mag_a;
                divisor <= mag_b;
                sign_q  <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
                sign_r  <= data_operandA[WIDTH-1];
                div0    <= (data_operandB == '0);
                cnt     <= '0;
                busy    <= (data_operandB != '0);
                state   <= (data_operandB == '0) ? DONE : RUN;
            end
        end
    end

endmodule
